// File: rtl/rasterizer_pkg.sv
// rasterizer_pkg: shared coordinate and edge-value types for the rasterizer backend.
package rasterizer_pkg;
  localparam int DW = 12;
  localparam int EW = 2 * DW;
  typedef logic signed [DW-1:0] coord_t;
  typedef logic signed [EW-1:0] edge_t;
endpackage

// File: rtl/rasterizer_backend_edge_walker.sv
// edge_walker: row and pixel accumulators for one edge function.
module edge_walker
  import rasterizer_pkg::*;
#(
  parameter int W = EW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                step_x,
  input  logic                step_y,
  input  logic signed [W-1:0] init_val,
  input  logic signed [W-1:0] dx,
  input  logic signed [W-1:0] dy,
  output logic signed [W-1:0] val
);
  logic signed [W-1:0] row_q, pix_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q <= '0;
      pix_q <= '0;
    end else if (init) begin
      row_q <= init_val;
      pix_q <= init_val;
    end else if (step_y) begin
      row_q <= row_q + dy;
      pix_q <= row_q + dy;
    end else if (step_x) pix_q <= pix_q + dx;
  assign val = pix_q;
endmodule

// File: rtl/rasterizer_backend.sv
// rasterizer_backend: walks a triangle's bounding box row-major and emits covered
// pixels with their edge values, one per cycle, under valid/ready backpressure.
module rasterizer_backend
  import rasterizer_pkg::*;
#(
  parameter int DATAWIDTH = DW
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          i_dv,
  input  logic signed [DATAWIDTH-1:0]   i_bb_tl [2],
  input  logic signed [DATAWIDTH-1:0]   i_bb_br [2],
  input  logic signed [2*DATAWIDTH-1:0] i_edge_val0,
  input  logic signed [2*DATAWIDTH-1:0] i_edge_val1,
  input  logic signed [2*DATAWIDTH-1:0] i_edge_val2,
  input  logic signed [DATAWIDTH-1:0]   i_edge_delta0 [2],
  input  logic signed [DATAWIDTH-1:0]   i_edge_delta1 [2],
  input  logic signed [DATAWIDTH-1:0]   i_edge_delta2 [2],
  input  logic [2*DATAWIDTH-1:0]        i_area_inv,
  output logic signed [DATAWIDTH-1:0]   o_x,
  output logic signed [DATAWIDTH-1:0]   o_y,
  output logic signed [2*DATAWIDTH-1:0] o_w0,
  output logic signed [2*DATAWIDTH-1:0] o_w1,
  output logic signed [2*DATAWIDTH-1:0] o_w2,
  output logic [2*DATAWIDTH-1:0]        o_area_inv,
  output logic                          o_dv,
  input  logic                          i_ready
);
  localparam int EDGEW = 2 * DATAWIDTH;
  typedef enum logic [1:0] {IDLE, INIT, WALK} state_t;
  state_t                     state_q;
  logic signed [DATAWIDTH-1:0] tl_q [2], br_q [2], dlt_q [3][2];
  logic signed [DATAWIDTH-1:0] x_q, y_q;
  logic signed [EDGEW-1:0]     ev_q [3], init_v [3], dx_e [3], dy_e [3], e_v [3];
  logic [EDGEW-1:0]            area_q;
  logic adv, empty, cov, walk_adv, last_x, last_y;
  assign ready    = state_q == IDLE;
  assign adv      = !o_dv || i_ready;
  assign empty    = tl_q[0] > br_q[0] || tl_q[1] > br_q[1];
  assign last_x   = x_q == br_q[0];
  assign last_y   = y_q == br_q[1];
  assign walk_adv = state_q == WALK && adv;
  assign cov      = !(e_v[0][EDGEW-1] | e_v[1][EDGEW-1] | e_v[2][EDGEW-1]);
  for (genvar k = 0; k < 3; k++) begin : g_edge
    assign dx_e[k]   = EDGEW'(dlt_q[k][0]);
    assign dy_e[k]   = EDGEW'(dlt_q[k][1]);
    assign init_v[k] = ev_q[k] + EDGEW'(tl_q[0]) * dx_e[k] + EDGEW'(tl_q[1]) * dy_e[k];
    edge_walker #(.W(EDGEW)) u_edge (
      .clk,
      .rst,
      .init    (state_q == INIT && !empty),
      .step_x  (walk_adv && !last_x),
      .step_y  (walk_adv && last_x && !last_y),
      .init_val(init_v[k]),
      .dx      (dx_e[k]),
      .dy      (dy_e[k]),
      .val     (e_v[k])
    );
  end
  // A pending pixel drains in any state, so a new triangle can be latched behind it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      tl_q       <= '{default: '0};
      br_q       <= '{default: '0};
      dlt_q      <= '{default: '0};
      ev_q       <= '{default: '0};
      area_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      o_x        <= '0;
      o_y        <= '0;
      o_w0       <= '0;
      o_w1       <= '0;
      o_w2       <= '0;
      o_area_inv <= '0;
      o_dv       <= 1'b0;
    end else begin
      if (o_dv && i_ready) o_dv <= 1'b0;
      case (state_q)
        IDLE:
          if (i_dv) begin
            tl_q     <= i_bb_tl;
            br_q     <= i_bb_br;
            ev_q     <= '{i_edge_val0, i_edge_val1, i_edge_val2};
            dlt_q[0] <= i_edge_delta0;
            dlt_q[1] <= i_edge_delta1;
            dlt_q[2] <= i_edge_delta2;
            area_q   <= i_area_inv;
            state_q  <= INIT;
          end
        INIT: begin
          x_q     <= tl_q[0];
          y_q     <= tl_q[1];
          state_q <= empty ? IDLE : WALK;
        end
        WALK:
          if (adv) begin
            o_dv <= cov;
            if (cov) begin
              o_x        <= x_q;
              o_y        <= y_q;
              o_w0       <= e_v[0];
              o_w1       <= e_v[1];
              o_w2       <= e_v[2];
              o_area_inv <= area_q;
            end
            if (last_x) begin
              x_q <= tl_q[0];
              y_q <= y_q + DATAWIDTH'(1);
              if (last_y) state_q <= IDLE;
            end else x_q <= x_q + DATAWIDTH'(1);
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rasterizer_backend.sv
// tb_rasterizer_backend: directed and random triangles checked against a
// brute-force pixel-coverage model with an in-order scoreboard.
module tb_rasterizer_backend;
  import rasterizer_pkg::*;
  logic   clk = 1'b0, rst = 1'b1, ready, i_dv = 1'b0, i_ready = 1'b1, o_dv;
  coord_t i_bb_tl [2], i_bb_br [2], i_edge_delta0 [2], i_edge_delta1 [2], i_edge_delta2 [2];
  edge_t  i_edge_val0, i_edge_val1, i_edge_val2, o_w0, o_w1, o_w2;
  coord_t o_x, o_y;
  logic [EW-1:0]  i_area_inv, o_area_inv;
  logic [127:0]   outv, held;
  logic [127:0]   exp_q [$];
  int checks = 0, errors = 0, n_acc = 0;
  int t_tl [2], t_br [2], t_ev [3], t_d [3][2], t_area;
  bit stalled = 0, rand_done = 0;
  always #5 clk = ~clk;
  assign outv = {8'b0, o_x, o_y, o_w0, o_w1, o_w2, o_area_inv};
  rasterizer_backend dut (
    .clk(clk), .rst(rst), .ready(ready), .i_dv(i_dv),
    .i_bb_tl(i_bb_tl), .i_bb_br(i_bb_br),
    .i_edge_val0(i_edge_val0), .i_edge_val1(i_edge_val1), .i_edge_val2(i_edge_val2),
    .i_edge_delta0(i_edge_delta0), .i_edge_delta1(i_edge_delta1), .i_edge_delta2(i_edge_delta2),
    .i_area_inv(i_area_inv), .o_x(o_x), .o_y(o_y), .o_w0(o_w0), .o_w1(o_w1), .o_w2(o_w2),
    .o_area_inv(o_area_inv), .o_dv(o_dv), .i_ready(i_ready)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  // Monitor: stalled outputs must hold; accepted pixels must match the model in order.
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_dv", o_dv, 1);
        chk("hold_out", outv, held);
      end
      stalled = o_dv && !i_ready;
      held = outv;
      if (o_dv && i_ready) begin
        n_acc++;
        if (exp_q.size() == 0) chk("extra_pixel", outv, 0);
        else chk("pixel", outv, exp_q.pop_front());
      end
    end
  end
  task automatic set_tri(input int tlx, input int tly, input int brx, input int bry);
    t_tl = '{tlx, tly};
    t_br = '{brx, bry};
    t_ev = '{0, 16, 0};
    t_d  = '{'{4, 0}, '{-4, -4}, '{0, 4}};
    t_area = 'h00abcd;
  endtask
  task automatic send();
    int n = 0;
    while (!ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready", ready, 1);
    i_bb_tl = '{coord_t'(t_tl[0]), coord_t'(t_tl[1])};
    i_bb_br = '{coord_t'(t_br[0]), coord_t'(t_br[1])};
    i_edge_val0 = edge_t'(t_ev[0]);
    i_edge_val1 = edge_t'(t_ev[1]);
    i_edge_val2 = edge_t'(t_ev[2]);
    i_edge_delta0 = '{coord_t'(t_d[0][0]), coord_t'(t_d[0][1])};
    i_edge_delta1 = '{coord_t'(t_d[1][0]), coord_t'(t_d[1][1])};
    i_edge_delta2 = '{coord_t'(t_d[2][0]), coord_t'(t_d[2][1])};
    i_area_inv = EW'(t_area);
    i_dv = 1'b1;
    for (int y = t_tl[1]; y <= t_br[1]; y++)
      for (int x = t_tl[0]; x <= t_br[0]; x++) begin
        int e [3];
        for (int k = 0; k < 3; k++) e[k] = t_ev[k] + x * t_d[k][0] + y * t_d[k][1];
        if (e[0] >= 0 && e[1] >= 0 && e[2] >= 0)
          exp_q.push_back({8'b0, DW'(x), DW'(y), EW'(e[0]), EW'(e[1]), EW'(e[2]), EW'(t_area)});
      end
    @(posedge clk); #1;
    i_dv = 1'b0;
  endtask
  task automatic run_idle(output int n, output int first, output logic [127:0] fv);
    n = 0;
    first = -1;
    fv = '0;
    while (!ready && n < 300) begin
      @(posedge clk); #1; n++;
      if (o_dv && first < 0) begin
        first = n;
        fv = outv;
      end
    end
    chk("idle_timeout", ready, 1);
  endtask
  task automatic drain();
    int n = 0;
    while (!(ready && !o_dv && exp_q.size() == 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    int n, first, base;
    logic [127:0] fv;
    i_bb_tl = '{default: '0};
    i_bb_br = '{default: '0};
    i_edge_delta0 = '{default: '0};
    i_edge_delta1 = '{default: '0};
    i_edge_delta2 = '{default: '0};
    {i_edge_val0, i_edge_val1, i_edge_val2, i_area_inv} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_dv", o_dv, 0);
    chk("rst_out", outv, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // basic triangle, no stalls
    base = n_acc;
    set_tri(0, 0, 4, 4);
    send();
    run_idle(n, first, fv);
    chk("basic_cycles", n, 26);
    chk("basic_latency", first, 2);
    chk("basic_first", fv, {8'b0, 12'd0, 12'd0, 24'd0, 24'd16, 24'd0, 24'habcd});
    drain();
    chk("basic_count", n_acc - base, 15);
    chk("basic_last", outv, {8'b0, 12'd0, 12'd4, 24'd0, 24'd0, 24'd16, 24'habcd});
    // backpressure on the second pixel
    base = n_acc;
    send();
    n = 0;
    while (n_acc < base + 1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    i_ready = 1'b0;
    chk("bp_pixel", outv, {8'b0, 12'd1, 12'd0, 24'd4, 24'd12, 24'd0, 24'habcd});
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held", outv, {8'b0, 12'd1, 12'd0, 24'd4, 24'd12, 24'd0, 24'habcd});
    i_ready = 1'b1;
    drain();
    chk("bp_count", n_acc - base, 15);
    // single pixel box
    base = n_acc;
    set_tri(2, 1, 2, 1);
    send();
    run_idle(n, first, fv);
    chk("single_cycles", n, 2);
    chk("single_pixel", fv, {8'b0, 12'd2, 12'd1, 24'd8, 24'd4, 24'd4, 24'habcd});
    drain();
    chk("single_count", n_acc - base, 1);
    // empty box
    base = n_acc;
    set_tri(5, 0, 4, 4);
    send();
    run_idle(n, first, fv);
    chk("empty_cycles", n, 1);
    chk("empty_first", first, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_count", n_acc - base, 0);
    // reset after the 5th pixel
    base = n_acc;
    set_tri(0, 0, 4, 4);
    send();
    n = 0;
    while (n_acc < base + 5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_dv", o_dv, 0);
    chk("mid_rst_out", outv, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_count", n_acc - base, 5);
    // back-to-back behind a stalled last pixel
    base = n_acc;
    i_ready = 1'b0;
    set_tri(2, 1, 2, 1);
    send();
    run_idle(n, first, fv);
    chk("b2b_pending", {ready, o_dv}, 2'b11);
    set_tri(0, 0, 4, 4);
    send();
    i_ready = 1'b1;
    drain();
    chk("b2b_count", n_acc - base, 16);
    // random triangles under random backpressure
    fork
      begin
        for (int t = 0; t < 20; t++) begin
          t_tl[0] = $urandom_range(12) - 6;
          t_tl[1] = $urandom_range(12) - 6;
          t_br[0] = ($urandom_range(7) == 0) ? t_tl[0] - 1 : t_tl[0] + $urandom_range(5);
          t_br[1] = t_tl[1] + $urandom_range(5);
          for (int k = 0; k < 3; k++) begin
            t_ev[k] = $urandom_range(120) - 60;
            t_d[k][0] = $urandom_range(16) - 8;
            t_d[k][1] = $urandom_range(16) - 8;
          end
          t_area = $urandom_range(24'hffffff);
          send();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
